ram_arbiter2: RTL and testbench

Two-master arbiter in front of the single-port 8K x 32 data RAM. Master 0 is the Cortex-M0 AHB-side memory port; master 1 is the DMA/loader engine. Master 0 has fixed priority. A starvation counter forces a master-1 grant after a bounded number of lost contentions. The block drives the RAM's cs/we/addr/wmask/wdata directly and routes the registered read data back to whichever master issued the read.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arbiter2_if.sv | 32 +++
 rtl/ram_arb_starve_ctr.sv | 29 ++
 rtl/ram_arbiter2.sv | 66 ++++++
 tb/tb_ram_arbiter2.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants and request record for the data RAM arbiter
package ram_arb_pkg;
  localparam int AW        = 13;
  localparam int DW        = 32;
  localparam int RAM_WORDS = 8192;
  localparam int M_CPU     = 0;
  localparam int M_DMA     = 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } ram_req_t;
endpackage

// File: rtl/ram_arbiter2_if.sv
// rtl/ram_arbiter2_if.sv - master request/response bus and RAM port bus
interface ram_arbiter2_if #(
  parameter int AW = ram_arb_pkg::AW,
  parameter int DW = ram_arb_pkg::DW
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] wmask;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, wmask, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

interface ram_port_if #(
  parameter int AW = ram_arb_pkg::AW,
  parameter int DW = ram_arb_pkg::DW
);
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wmask;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output cs, we, addr, wmask, wdata, input rdata);
  modport slave  (input cs, we, addr, wmask, wdata, output rdata);
endinterface

// File: rtl/ram_arb_starve_ctr.sv
// rtl/ram_arb_starve_ctr.sv - saturating count of master-1 lost contentions and force-grant flag
module ram_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic m1_req,
  input  logic m0_gnt,
  input  logic m1_gnt,
  output logic force_m1
);
  // Keep at least one bit so STARVE_LIMIT=0 still elaborates; count then sits at 0 == limit.
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (m1_gnt || !m1_req) begin
      count <= '0;
    end else if (m0_gnt && count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign force_m1 = (count == LIMIT);
endmodule

// File: rtl/ram_arbiter2.sv
// rtl/ram_arbiter2.sv - two-master fixed-priority RAM arbiter with starvation override
module ram_arbiter2 #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = ram_arb_pkg::AW,
  parameter int DW           = ram_arb_pkg::DW
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ram_arbiter2_if.slave   m0,
  ram_arbiter2_if.slave   m1,
  ram_port_if.master      ram
);
  import ram_arb_pkg::*;

  logic     gnt0;
  logic     gnt1;
  logic     force_m1;
  logic     rsp_valid;
  logic     rsp_owner;
  ram_req_t win;

  ram_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (HCLK),
    .resetn   (HRESETn),
    .m1_req   (m1.req),
    .m0_gnt   (gnt0),
    .m1_gnt   (gnt1),
    .force_m1 (force_m1)
  );

  assign gnt1   = HRESETn & m1.req & (~m0.req | force_m1);
  assign gnt0   = HRESETn & m0.req & ~gnt1;
  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  always_comb begin
    win = '{we: m0.we, addr: m0.addr, wdata: m0.wdata, wmask: m0.wmask};
    if (gnt1) begin
      win = '{we: m1.we, addr: m1.addr, wdata: m1.wdata, wmask: m1.wmask};
    end
  end

  assign ram.cs    = gnt0 | gnt1;
  assign ram.we    = ram.cs & win.we;
  assign ram.addr  = win.addr;
  assign ram.wdata = win.wdata;
  assign ram.wmask = win.wmask;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
    end else begin
      rsp_valid <= ram.cs & ~win.we;
      rsp_owner <= gnt1;
    end
  end

  // Gate with reset so a read granted just before reset never surfaces.
  assign m0.rvalid = HRESETn & rsp_valid & (rsp_owner == 1'(M_CPU));
  assign m1.rvalid = HRESETn & rsp_valid & (rsp_owner == 1'(M_DMA));
  assign m0.rdata  = m0.rvalid ? ram.rdata : '0;
  assign m1.rdata  = m1.rvalid ? ram.rdata : '0;
endmodule

// File: tb/tb_ram_arbiter2.sv
// tb/tb_ram_arbiter2.sv - vector table plus scoreboard bench for ram_arbiter2
module tb_ram_arbiter2;
  logic HCLK;
  logic HRESETn;

  ram_arbiter2_if #(.AW(13), .DW(32)) m0_bus ();
  ram_arbiter2_if #(.AW(13), .DW(32)) m1_bus ();
  ram_port_if     #(.AW(13), .DW(32)) ram_bus ();

  ram_arbiter2 #(.STARVE_LIMIT(4), .AW(13), .DW(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .ram     (ram_bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  bit [31:0] ram_mem [0:8191];
  bit [31:0] exp_mem [0:8191];

  always @(posedge HCLK) begin
    if (ram_bus.cs) begin
      if (ram_bus.we)
        ram_mem[ram_bus.addr] <= (ram_mem[ram_bus.addr] & ram_bus.wmask) | (ram_bus.wdata & ~ram_bus.wmask);
      else
        ram_bus.rdata <= ram_mem[ram_bus.addr];
    end
  end

  typedef struct {
    bit        rst;
    bit        r0, w0;
    bit [12:0] a0;
    bit [31:0] d0, k0;
    bit        r1, w1;
    bit [12:0] a1;
    bit [31:0] d1, k1;
    bit        e0, e1;
  } vec_t;

  typedef struct {
    bit        owner;
    bit [31:0] data;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(bit rst, bit r0, bit w0, bit [12:0] a0, bit [31:0] d0, bit [31:0] k0,
                              bit r1, bit w1, bit [12:0] a1, bit [31:0] d1, bit [31:0] k1,
                              bit e0, bit e1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.k0 = k0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.k1 = k1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    bit        w;
    bit [12:0] a;
    bit [31:0] d, k;
    rsp_t      r;
    HRESETn      = v.rst;
    m0_bus.req   = v.r0; m0_bus.we = v.w0; m0_bus.addr = v.a0; m0_bus.wdata = v.d0; m0_bus.wmask = v.k0;
    m1_bus.req   = v.r1; m1_bus.we = v.w1; m1_bus.addr = v.a1; m1_bus.wdata = v.d1; m1_bus.wmask = v.k1;
    #3;
    if (!v.rst) begin
      chk({tag, "_rvalid0"}, 32'(m0_bus.rvalid), 0);
      chk({tag, "_rvalid1"}, 32'(m1_bus.rvalid), 0);
      sbq.delete();
    end else if (sbq.size() > 0) begin
      r = sbq.pop_front();
      chk({tag, "_rvalid0"}, 32'(m0_bus.rvalid), 32'(!r.owner));
      chk({tag, "_rvalid1"}, 32'(m1_bus.rvalid), 32'(r.owner));
      chk({tag, "_rdata0"}, m0_bus.rdata, r.owner ? 32'h0 : r.data);
      chk({tag, "_rdata1"}, m1_bus.rdata, r.owner ? r.data : 32'h0);
    end else begin
      chk({tag, "_rvalid0"}, 32'(m0_bus.rvalid), 0);
      chk({tag, "_rvalid1"}, 32'(m1_bus.rvalid), 0);
    end
    chk({tag, "_gnt0"}, 32'(m0_bus.gnt), 32'(v.e0));
    chk({tag, "_gnt1"}, 32'(m1_bus.gnt), 32'(v.e1));
    chk({tag, "_cs"}, 32'(ram_bus.cs), 32'(v.e0 | v.e1));
    if (v.e0 | v.e1) begin
      w = v.e1 ? v.w1 : v.w0;
      a = v.e1 ? v.a1 : v.a0;
      d = v.e1 ? v.d1 : v.d0;
      k = v.e1 ? v.k1 : v.k0;
      chk({tag, "_ram_we"}, 32'(ram_bus.we), 32'(w));
      chk({tag, "_ram_addr"}, 32'(ram_bus.addr), 32'(a));
      if (w) begin
        chk({tag, "_ram_wdata"}, ram_bus.wdata, d);
        chk({tag, "_ram_wmask"}, ram_bus.wmask, k);
        exp_mem[a] = (exp_mem[a] & k) | (d & ~k);
      end else begin
        r.owner = v.e1;
        r.data  = exp_mem[a];
        sbq.push_back(r);
      end
    end else begin
      chk({tag, "_ram_we_idle"}, 32'(ram_bus.we), 0);
    end
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wmask = '0;
    m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wmask = '0;
    @(posedge HCLK);
    #1;

    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1,0,0,0,0, 1,0,0,0,0, 0,0));
    vecs.push_back(mk(1, 1,0,0,0,0, 1,0,0,0,0, 1,0));
    vecs.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,0, 1,1,13'h10,32'hDEADBEEF,32'h0, 0,1));
    vecs.push_back(mk(1, 0,0,0,0,0, 1,0,13'h10,0,0, 0,1));
    vecs.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    vecs.push_back(mk(1, 0,0,0,0,0, 1,1,13'h20,32'hFFFFFFFF,32'h0, 0,1));
    vecs.push_back(mk(1, 1,1,13'h20,32'h0,32'hFFFF0000, 0,0,0,0,0, 1,0));
    vecs.push_back(mk(1, 1,0,13'h20,0,0, 0,0,0,0,0, 1,0));
    vecs.push_back(mk(1, 0,0,0,0,0, 1,1,13'h1,32'h11111111,32'h0, 0,1));
    vecs.push_back(mk(1, 0,0,0,0,0, 1,1,13'h2,32'h22222222,32'h0, 0,1));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Alternating single-master reads, one per cycle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) apply(mk(1, 1,0,13'h1,0,0, 0,0,0,0,0, 1,0), $sformatf("alt%0d", i));
      else            apply(mk(1, 0,0,0,0,0, 1,0,13'h2,0,0, 0,1), $sformatf("alt%0d", i));
    end

    // Continuous contention: m1 forced through every fifth cycle.
    for (int i = 0; i < 15; i++)
      apply(mk(1, 1,0,13'h1,0,0, 1,0,13'h2,0,0, i % 5 != 4, i % 5 == 4), $sformatf("starve%0d", i));

    // Counter built up to 3, m0 read granted, then reset the next cycle.
    apply(mk(1, 1,0,13'h1,0,0, 1,0,13'h2,0,0, 1,0), "pre0");
    apply(mk(1, 1,0,13'h1,0,0, 1,0,13'h2,0,0, 1,0), "pre1");
    apply(mk(1, 1,0,13'h1,0,0, 1,0,13'h2,0,0, 1,0), "rd_before_rst");
    apply(mk(0, 1,0,13'h1,0,0, 1,0,13'h2,0,0, 0,0), "mid_rst");
    for (int i = 0; i < 5; i++)
      apply(mk(1, 1,0,13'h1,0,0, 1,0,13'h2,0,0, i != 4, i == 4), $sformatf("post_rst%0d", i));
    apply(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0), "drain0");
    apply(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0), "drain1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
